pc_redirect_unit: RTL
=====================

# pc_redirect_unit

Owns the fetch program counter of the RV32I five-stage pipeline and turns control-flow decisions into PC updates and pipeline flushes. Sits directly downstream of the EX-stage branch comparator: consumes its taken flag (`BranchE`) together with JALR/JAL targets, selects the next PC by priority, and drives `FlushD`/`FlushE`. It also traps misaligned targets and counts accepted redirects.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `StallF`  in  1  hazard-unit fetch stall; hold PC.
- `BranchE`  in  1  conditional branch in EX is taken.
- `BranchTargetE`  in  32  PC_E + B-immediate.
- `JalrE`  in  1  JALR in EX.
- `JalrTargetE`  in  32  rs1 + I-immediate, bit 0 not yet cleared.
- `JalD`  in  1  JAL decoded in ID.
- `JalTargetD`  in  32  PC_D + J-immediate.
- `PCF`  out  32  registered fetch PC.
- `FlushD`  out  1  clear IF/ID register this cycle.
- `FlushE`  out  1  clear ID/EX register this cycle.
- `TrapF`  out  1  registered, sticky misaligned-target trap.
- `TrapPC`  out  32  registered offending target.
- `RedirectCount`  out  32  registered count of accepted redirects.

## Operation
- States: RUN, TRAP. Reset → RUN.
- Target select in RUN, strict priority:
  - 1. EX redirect: `BranchE` → `BranchTargetE`; else `JalrE` → `{JalrTargetE[31:1],1'b0}`. `BranchE` and `JalrE` never both legal; if both high, `BranchE` wins.
  - 2. ID redirect: `JalD` and `~StallF` → `JalTargetD`.
  - 3. Sequential: `~StallF` → `PCF + 4`, modulo 2^32 (wrap 32'hFFFF_FFFC → 0).
  - 4. Otherwise hold `PCF`.
- EX redirect ignores `StallF`. ID redirect is suppressed by `StallF`; JAL stays in ID and re-asserts. ID redirect is suppressed by any EX redirect because ID is being flushed.
- Alignment: any selected redirect target with bits [1:0] ≠ 0 (after JALR bit-0 clear) is not loaded. Next state TRAP, `TrapF`←1, `TrapPC`←target, `PCF` holds, counter unchanged. PC+4 is never checked.
- Flushes, combinational, in RUN: `FlushE` = EX redirect; `FlushD` = EX redirect | accepted ID redirect. A trapping redirect still asserts its flushes in that cycle.
- TRAP: all inputs ignored; `PCF`, `TrapPC`, `RedirectCount` hold; `FlushD`=`FlushE`=1 continuously. Exit only through reset.
- `RedirectCount` +1 per accepted, aligned redirect (EX or ID); wraps modulo 2^32.

## Timing
- Reset (`rst_n`=0 at edge): `PCF`=`RESET_PC`, `TrapF`=0, `TrapPC`=0, `RedirectCount`=0, state RUN. While `rst_n`=0, `FlushD`=`FlushE`=1. Reset overrides TRAP and any in-flight redirect.
- Redirect latency: a condition valid in cycle n gives `PCF`=target in n+1. Flushes act in cycle n, with no bubble beyond the architectural ones: 2 for EX redirects, 1 for JAL.
- `TrapF` rises in n+1 for a misaligned target selected in n.
- No combinational path from `PCF` to `FlushD`/`FlushE`.

## Structure
- Shared package `rv_pipe_pkg`: state encoding (RUN, TRAP), `PC_STEP`=4, default `RESET_PC`, `misaligned(addr)` function (addr[1:0]≠0).
- One sub-module, `pc_next_mux`: purely combinational priority select. Outputs are next PC, redirect-accepted, EX-redirect, and misaligned. The parent holds all registers and the FSM.

## Test plan
- Reset, then 3 cycles free-run → `PCF` = 0, 4, 8, C. Flushes 0. `RedirectCount`=0.
- `BranchE`=1, `BranchTargetE`=32'h100, `StallF`=1 in the same cycle → `FlushD`=`FlushE`=1 that cycle; next `PCF`=32'h100, `RedirectCount`=1.
- `JalD`=1, `JalTargetD`=32'h40, `StallF`=1 for 2 cycles, then 0 → PC holds and `FlushD`=0 while stalled. On release, `FlushD`=1 and `PCF`=32'h40 next cycle.
- `JalrE`=1, `JalrTargetE`=32'h205 with `JalD`=1 → `PCF`=32'h204 (bit 0 cleared, JAL ignored), `FlushD`=`FlushE`=1. Then repeat with `JalrTargetE`=32'h206 → `TrapF`=1 and `TrapPC`=32'h206 next cycle. `PCF` and count hold, and the flushes stay 1 through 5 further cycles of random inputs.
- `PCF`=32'hFFFF_FFFC, no redirect → `PCF`=0 next cycle, no trap.
- In TRAP, `rst_n`=0 for one edge → all outputs at reset values, and sequential fetch resumes from `RESET_PC`.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the RV32I pipeline front end: the PC redirect FSM
// state encoding, PC width/step constants, the default reset PC and an
// alignment helper used when checking redirect targets.
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    // Sequential fetch advances by one 32-bit instruction
    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = XLEN'(0);

    // Low address bits that must be zero for a 4-byte aligned fetch target
    localparam logic [XLEN-1:0] ALIGN_MASK       = XLEN'(3);

    // Redirect unit modes: normal fetch, or parked after a misaligned target
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_e;

    // True when addr is not a legal 4-byte aligned instruction address
    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

endpackage : rv_pipe_pkg

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Purely combinational next-PC priority select for the fetch stage.
// Priority: EX redirect (branch, then JALR) > ID redirect (JAL, not stalled)
// > sequential PC+4 (not stalled) > hold.
//
// Ports:
//   pc_i             current fetch PC
//   stall_i          fetch stall from the hazard unit
//   branch_i         taken conditional branch in EX
//   branch_target_i  branch target
//   jalr_i           JALR in EX
//   jalr_target_i    JALR target with bit 0 still raw
//   jal_i            JAL decoded in ID
//   jal_target_i     JAL target
//   next_pc_o        selected next PC (the redirect target when redirecting)
//   redirect_o       an EX or ID redirect was selected this cycle
//   ex_redirect_o    the selected redirect came from EX
//   misaligned_o     the selected redirect target is misaligned
// -----------------------------------------------------------------------------
module pc_next_mux
    import rv_pipe_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic            jal_i,
    input  logic [XLEN-1:0] jal_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            redirect_o,
    output logic            ex_redirect_o,
    output logic            misaligned_o
);

    logic            ex_redirect;
    logic            id_redirect;
    logic [XLEN-1:0] ex_target;

    // Branch wins over JALR if both are ever asserted; JALR clears bit 0
    assign ex_redirect = branch_i | jalr_i;
    assign ex_target   = branch_i ? branch_target_i
                                  : (jalr_target_i & ~XLEN'(1));

    // JAL in ID is dropped while stalled (it re-asserts) and when EX flushes ID
    assign id_redirect = jal_i & ~stall_i & ~ex_redirect;

    // Next-PC priority select
    always_comb begin
        next_pc_o = pc_i;
        if (ex_redirect) begin
            next_pc_o = ex_target;
        end else if (id_redirect) begin
            next_pc_o = jal_target_i;
        end else if (!stall_i) begin
            next_pc_o = pc_i + PC_STEP;
        end
    end

    assign redirect_o    = ex_redirect | id_redirect;
    assign ex_redirect_o = ex_redirect;
    // Sequential PC+4 is never alignment-checked
    assign misaligned_o  = redirect_o & misaligned(next_pc_o);

endmodule : pc_next_mux

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
// Owns the fetch PC of the RV32I five-stage pipeline. Turns EX-stage branch /
// JALR decisions and ID-stage JAL into PC updates and IF/ID, ID/EX flushes,
// traps misaligned redirect targets (sticky until reset) and counts accepted
// redirects.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   StallF            fetch stall, holds PC (does not block EX redirects)
//   BranchE           taken conditional branch in EX
//   BranchTargetE     branch target
//   JalrE             JALR in EX
//   JalrTargetE       JALR target, bit 0 not yet cleared
//   JalD              JAL decoded in ID
//   JalTargetD        JAL target
//   PCF               registered fetch PC
//   FlushD            clear IF/ID this cycle (combinational)
//   FlushE            clear ID/EX this cycle (combinational)
//   TrapF             registered sticky misaligned-target trap
//   TrapPC            registered offending target
//   RedirectCount     registered count of accepted aligned redirects
// -----------------------------------------------------------------------------
module pc_redirect_unit
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE,
    input  logic        JalrE,
    input  logic [31:0] JalrTargetE,
    input  logic        JalD,
    input  logic [31:0] JalTargetD,
    output logic [31:0] PCF,
    output logic        FlushD,
    output logic        FlushE,
    output logic        TrapF,
    output logic [31:0] TrapPC,
    output logic [31:0] RedirectCount
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic            ex_redirect;
    logic            target_misaligned;

    pc_next_mux u_pc_next_mux (
        .pc_i            (pc_q),
        .stall_i         (StallF),
        .branch_i        (BranchE),
        .branch_target_i (BranchTargetE),
        .jalr_i          (JalrE),
        .jalr_target_i   (JalrTargetE),
        .jal_i           (JalD),
        .jal_target_i    (JalTargetD),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect),
        .ex_redirect_o   (ex_redirect),
        .misaligned_o    (target_misaligned)
    );

    // Next-state logic: RUN loads the selected PC or traps; TRAP holds everything
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        count_d   = count_q;
        unique case (state_q)
            ST_RUN: begin
                if (target_misaligned) begin
                    state_d   = ST_TRAP;
                    trap_d    = 1'b1;
                    trap_pc_d = next_pc;
                end else begin
                    pc_d = next_pc;
                    if (redirect) begin
                        count_d = count_q + XLEN'(1);
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            count_q   <= count_d;
        end
    end

    // Flushes depend only on control inputs and state, never on PCF.
    // A trapping redirect still flushes in its own cycle; TRAP and reset flush always.
    assign FlushE = ~rst_n | (state_q == ST_TRAP) | ex_redirect;
    assign FlushD = ~rst_n | (state_q == ST_TRAP) | redirect;

    assign PCF           = pc_q;
    assign TrapF         = trap_q;
    assign TrapPC        = trap_pc_q;
    assign RedirectCount = count_q;

endmodule : pc_redirect_unit
